// File: rtl/operand_fetch_pkg.sv
// Shared constants and types for the operand-fetch stage and its scoreboard.
package operand_fetch_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;
    localparam int OP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              rd_we;
        logic [OP_W-1:0]   op;
    } instr_t;

endpackage

// File: rtl/operand_fetch_op_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module op_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] q_a_addr,
    input  logic [ADDR_W-1:0] q_b_addr,
    input  logic [ADDR_W-1:0] q_c_addr,
    output logic              hit_a,
    output logic              hit_b,
    output logic              hit_c,
    output logic [NREGS-1:0]  pending
);

    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] eff;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bits
            assign set_vec[gi] = set_en & (set_addr == ADDR_W'(gi));
            assign clr_vec[gi] = clr_en & (clr_addr == ADDR_W'(gi));
        end
    endgenerate

    // A writeback this cycle already resolves its register for hazard purposes,
    // and a new issue to the same register keeps it pending (set wins).
    assign eff          = pending_reg & ~clr_vec;
    assign pending_next = eff | set_vec;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign hit_a   = eff[q_a_addr];
    assign hit_b   = eff[q_b_addr];
    assign hit_c   = eff[q_c_addr];
    assign pending = pending_reg;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: issues register-file reads for ID instructions, hands operands
// to EX over valid/ready, forwards WB writes and tracks pending destinations.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic [OP_W-1:0]   id_op,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_opa,
    output logic [DATA_W-1:0] ex_opb,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_rd_we,
    output logic [OP_W-1:0]   ex_op,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_raddra,
    output logic [ADDR_W-1:0] rf_raddrb,
    input  logic [DATA_W-1:0] rf_douta,
    input  logic [DATA_W-1:0] rf_doutb,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wen,
    output logic [NREGS-1:0]  busy_mask
);

    state_t            state_reg;
    state_t            state_next;
    instr_t            id_instr;
    logic [ADDR_W-1:0] raddra_reg;
    logic [ADDR_W-1:0] raddrb_reg;
    logic [ADDR_W-1:0] rd_reg;
    logic              rd_we_reg;
    logic [OP_W-1:0]   op_reg;
    logic [DATA_W-1:0] opa_reg;
    logic [DATA_W-1:0] opb_reg;
    logic              ex_valid_reg;
    logic [DATA_W-1:0] opa_next;
    logic [DATA_W-1:0] opb_next;
    logic              hit_a;
    logic              hit_b;
    logic              hit_c;
    logic              hazard;
    logic              accept;
    logic              capture;
    logic              retire;

    assign id_instr = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd, rd_we: id_rd_we, op: id_op};

    // Write port is a straight pass-through so the RF writes at this cycle's negedge.
    assign rf_wen   = wb_valid & nrst;
    assign rf_waddr = wb_rd;
    assign rf_wdata = wb_data;

    op_scoreboard u_scoreboard (
        .clk      (clk),
        .nrst     (nrst),
        .set_en   (accept & id_instr.rd_we),
        .set_addr (id_instr.rd),
        .clr_en   (rf_wen),
        .clr_addr (wb_rd),
        .q_a_addr (id_instr.rs1),
        .q_b_addr (id_instr.rs2),
        .q_c_addr (id_instr.rd),
        .hit_a    (hit_a),
        .hit_b    (hit_b),
        .hit_c    (hit_c),
        .pending  (busy_mask)
    );

    always_comb begin
        state_next = state_reg;
        id_ready   = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        hazard     = hit_a | hit_b | (id_instr.rd_we & hit_c);
        case (state_reg)
            ST_IDLE: begin
                id_ready = nrst & ~hazard;
                accept   = id_valid & id_ready;
                if (accept) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                capture    = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (ex_ready) begin
                    retire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The RF returns the old value on a same-negedge read/write, so a writeback
    // during the read cycle has to be bypassed here.
    assign opa_next = (rf_wen && (rf_waddr == raddra_reg)) ? rf_wdata : rf_douta;
    assign opb_next = (rf_wen && (rf_waddr == raddrb_reg)) ? rf_wdata : rf_doutb;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            raddra_reg   <= '0;
            raddrb_reg   <= '0;
            rd_reg       <= '0;
            rd_we_reg    <= 1'b0;
            op_reg       <= '0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            ex_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                raddra_reg <= id_instr.rs1;
                raddrb_reg <= id_instr.rs2;
                rd_reg     <= id_instr.rd;
                rd_we_reg  <= id_instr.rd_we;
                op_reg     <= id_instr.op;
            end
            if (capture) begin
                opa_reg      <= opa_next;
                opb_reg      <= opb_next;
                ex_valid_reg <= 1'b1;
            end
            if (retire) begin
                ex_valid_reg <= 1'b0;
            end
        end
    end

    assign rf_raddra = raddra_reg;
    assign rf_raddrb = raddrb_reg;
    assign ex_valid  = ex_valid_reg;
    assign ex_opa    = opa_reg;
    assign ex_opb    = opb_reg;
    assign ex_rd     = rd_reg;
    assign ex_rd_we  = rd_we_reg;
    assign ex_op     = op_reg;

endmodule
